// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, functs, ALU ops,
// FSM state codes and datapath select codes.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_AND = 3'd2, ALU_OR  = 3'd3,
    ALU_SLT = 3'd4, ALU_SLL = 3'd5, ALU_SRL = 3'd6, ALU_LUI = 3'd7
  } aluOp_t;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,  S_DECODE = 4'd1,  S_EXE_R  = 4'd2,  S_EXE_I = 4'd3,
    S_WB_ALU   = 4'd4,  S_MEM_ADDR = 4'd5, S_MEM_RD = 4'd6, S_MEM_WR = 4'd7,
    S_WB_MEM   = 4'd8,  S_BRANCH = 4'd9,  S_JUMP   = 4'd10, S_JAL   = 4'd11,
    S_JR       = 4'd12
  } state_t;

  typedef enum logic [2:0] {
    CLS_R = 3'd0, CLS_JR = 3'd1, CLS_I = 3'd2, CLS_MEM = 3'd3,
    CLS_BR = 3'd4, CLS_J = 3'd5, CLS_JAL = 3'd6, CLS_ILL = 3'd7
  } instrCls_t;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_RS     = 2'b11;

  localparam logic [1:0] RD_RT  = 2'b00;
  localparam logic [1:0] RD_RD  = 2'b01;
  localparam logic [1:0] RD_R31 = 2'b10;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  localparam logic [1:0] SRCB_RT    = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;

  // States that own the memory port and therefore run the watchdog.
  function automatic logic isMemState(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/mips_alu_dec.sv
// Combinational instruction classifier: OpCode/Funct -> instruction class,
// ALU op for R- and I-type execution, immediate extension mode and illegal flag.
module mips_alu_dec
  import mips_pkg::*;
(
  input  logic [5:0] OpCode,
  input  logic [5:0] Funct,
  output instrCls_t  instrCls,
  output aluOp_t     aluR,
  output aluOp_t     aluI,
  output logic [1:0] extI,
  output logic       illegal
);

  // Decode opcode/funct into class and per-class ALU/extender controls.
  always_comb begin
    instrCls = CLS_ILL;
    aluR     = ALU_ADD;
    aluI     = ALU_ADD;
    extI     = EXT_SIGN;
    case (OpCode)
      OP_RTYPE: begin
        case (Funct)
          FN_ADDU: begin instrCls = CLS_R; aluR = ALU_ADD; end
          FN_SUBU: begin instrCls = CLS_R; aluR = ALU_SUB; end
          FN_AND:  begin instrCls = CLS_R; aluR = ALU_AND; end
          FN_OR:   begin instrCls = CLS_R; aluR = ALU_OR;  end
          FN_SLT:  begin instrCls = CLS_R; aluR = ALU_SLT; end
          FN_SLL:  begin instrCls = CLS_R; aluR = ALU_SLL; end
          FN_SRL:  begin instrCls = CLS_R; aluR = ALU_SRL; end
          FN_JR:   instrCls = CLS_JR;
          default: instrCls = CLS_ILL;
        endcase
      end
      OP_ADDI, OP_ADDIU: instrCls = CLS_I;
      OP_SLTI: begin instrCls = CLS_I; aluI = ALU_SLT; end
      OP_ANDI: begin instrCls = CLS_I; aluI = ALU_AND; extI = EXT_ZERO; end
      OP_ORI:  begin instrCls = CLS_I; aluI = ALU_OR;  extI = EXT_ZERO; end
      OP_LUI:  begin instrCls = CLS_I; aluI = ALU_LUI; extI = EXT_LUI;  end
      OP_LW, OP_SW:   instrCls = CLS_MEM;
      OP_BEQ, OP_BNE: instrCls = CLS_BR;
      OP_J:    instrCls = CLS_J;
      OP_JAL:  instrCls = CLS_JAL;
      default: instrCls = CLS_ILL;
    endcase
  end

  assign illegal = (instrCls == CLS_ILL);

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control FSM with shared memory port, ready handshake,
// watchdog abort and sticky IllegalOp/BusErr flags.
module mips_mc_ctrl
  import mips_pkg::*;
#(
  parameter int ALUCTRL_W = 5,
  parameter int MAX_WAIT  = 15,
  parameter int WAIT_W    = 4
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [5:0]           OpCode,
  input  logic [5:0]           Funct,
  input  logic                 Zero,
  input  logic                 MemRdy,
  output logic                 MemReq,
  output logic                 MemW,
  output logic                 IorD,
  output logic                 IRWr,
  output logic                 PcWr,
  output logic [1:0]           PcSrc,
  output logic                 RegW,
  output logic [1:0]           RegDst,
  output logic [1:0]           Mem2R,
  output logic                 AluSrcA,
  output logic [1:0]           AluSrcB,
  output logic [1:0]           ExtOp,
  output logic [ALUCTRL_W-1:0] Aluctrl,
  output logic [3:0]           State,
  output logic                 IllegalOp,
  output logic                 BusErr
);

  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);

  state_t            state;
  logic [WAIT_W-1:0] wdog;
  instrCls_t         instrCls;
  aluOp_t            aluR, aluI, aluOp;
  logic [1:0]        extI;
  logic              illegal;
  logic              memWait, timeout;

  mips_alu_dec uDec (
    .OpCode  (OpCode),
    .Funct   (Funct),
    .instrCls(instrCls),
    .aluR    (aluR),
    .aluI    (aluI),
    .extI    (extI),
    .illegal (illegal)
  );

  assign memWait = isMemState(state);
  assign timeout = memWait && !MemRdy && (wdog == WAIT_LIM);
  assign State   = state;
  assign Aluctrl = ALUCTRL_W'(aluOp);

  // Sequencer, watchdog and sticky flags; wdog is zero whenever not waiting, so every memory state starts fresh.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state     <= S_FETCH;
      wdog      <= '0;
      IllegalOp <= 1'b0;
      BusErr    <= 1'b0;
    end else begin
      if (memWait && !MemRdy && (wdog != WAIT_LIM)) wdog <= wdog + WAIT_ONE;
      else                                          wdog <= '0;
      if (timeout) BusErr <= 1'b1;
      case (state)
        S_FETCH:    state <= MemRdy ? S_DECODE : S_FETCH;
        S_DECODE: begin
          if (illegal) begin
            IllegalOp <= 1'b1;
            state     <= S_FETCH;
          end else begin
            case (instrCls)
              CLS_R:   state <= S_EXE_R;
              CLS_JR:  state <= S_JR;
              CLS_I:   state <= S_EXE_I;
              CLS_MEM: state <= S_MEM_ADDR;
              CLS_BR:  state <= S_BRANCH;
              CLS_J:   state <= S_JUMP;
              CLS_JAL: state <= S_JAL;
              default: state <= S_FETCH;
            endcase
          end
        end
        S_EXE_R, S_EXE_I: state <= S_WB_ALU;
        S_MEM_ADDR: state <= (OpCode == OP_LW) ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD: begin
          if (MemRdy)       state <= S_WB_MEM;
          else if (timeout) state <= S_FETCH;
          else              state <= S_MEM_RD;
        end
        S_MEM_WR:   state <= (MemRdy || timeout) ? S_FETCH : S_MEM_WR;
        default:    state <= S_FETCH;
      endcase
    end
  end

  // Moore decode of state; commit strobes are qualified by MemRdy or Zero, and all held low in reset.
  always_comb begin
    MemReq  = 1'b0;
    MemW    = 1'b0;
    IorD    = 1'b0;
    IRWr    = 1'b0;
    PcWr    = 1'b0;
    PcSrc   = PC_ALU;
    RegW    = 1'b0;
    RegDst  = RD_RT;
    Mem2R   = M2R_ALUOUT;
    AluSrcA = 1'b0;
    AluSrcB = SRCB_RT;
    ExtOp   = EXT_ZERO;
    aluOp   = ALU_ADD;
    if (!Reset) begin
      MemReq = 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          MemReq  = 1'b1;
          AluSrcB = SRCB_FOUR;
          IRWr    = MemRdy;
          PcWr    = MemRdy;
        end
        S_DECODE: begin
          AluSrcB = SRCB_IMMSH;
          ExtOp   = EXT_SIGN;
        end
        S_EXE_R: begin
          AluSrcA = 1'b1;
          aluOp   = aluR;
        end
        S_EXE_I: begin
          AluSrcA = 1'b1;
          AluSrcB = SRCB_IMM;
          ExtOp   = extI;
          aluOp   = aluI;
        end
        S_WB_ALU: begin
          RegW   = 1'b1;
          RegDst = (OpCode == OP_RTYPE) ? RD_RD : RD_RT;
        end
        S_MEM_ADDR: begin
          AluSrcA = 1'b1;
          AluSrcB = SRCB_IMM;
          ExtOp   = EXT_SIGN;
        end
        S_MEM_RD: begin
          MemReq = 1'b1;
          IorD   = 1'b1;
        end
        S_MEM_WR: begin
          MemReq = 1'b1;
          MemW   = MemRdy;
          IorD   = 1'b1;
        end
        S_WB_MEM: begin
          RegW  = 1'b1;
          Mem2R = M2R_MDR;
        end
        S_BRANCH: begin
          AluSrcA = 1'b1;
          aluOp   = ALU_SUB;
          PcSrc   = PC_ALUOUT;
          PcWr    = (OpCode == OP_BEQ) ? Zero : !Zero;
        end
        S_JUMP: begin
          PcWr  = 1'b1;
          PcSrc = PC_JUMP;
        end
        S_JAL: begin
          PcWr   = 1'b1;
          PcSrc  = PC_JUMP;
          RegW   = 1'b1;
          RegDst = RD_R31;
          Mem2R  = M2R_PC;
        end
        S_JR: begin
          PcWr  = 1'b1;
          PcSrc = PC_RS;
        end
        default: MemReq = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed bench for mips_mc_ctrl: walks each instruction class through its
// state sequence, plus wait states, watchdog edge cases, illegal opcode and reset.
module tb_mips_mc_ctrl;

  logic       Clk = 1'b0;
  logic       Reset, Zero, MemRdy;
  logic [5:0] opc, fn;
  logic       MemReq, MemW, IorD, IRWr, PcWr, RegW, AluSrcA, IllegalOp, BusErr;
  logic [1:0] PcSrc, RegDst, Mem2R, AluSrcB, ExtOp;
  logic [4:0] Aluctrl;
  logic [3:0] State;
  int nChecks = 0;
  int nFails  = 0;

  always #5 Clk = ~Clk;

  mips_mc_ctrl #(.ALUCTRL_W(5), .MAX_WAIT(15), .WAIT_W(4)) dut (
    .Clk(Clk), .Reset(Reset), .OpCode(opc), .Funct(fn), .Zero(Zero), .MemRdy(MemRdy),
    .MemReq(MemReq), .MemW(MemW), .IorD(IorD), .IRWr(IRWr), .PcWr(PcWr), .PcSrc(PcSrc),
    .RegW(RegW), .RegDst(RegDst), .Mem2R(Mem2R), .AluSrcA(AluSrcA), .AluSrcB(AluSrcB),
    .ExtOp(ExtOp), .Aluctrl(Aluctrl), .State(State), .IllegalOp(IllegalOp), .BusErr(BusErr)
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic setInstr(input logic [31:0] instr);
    opc = instr[31:26];
    fn  = instr[5:0];
  endtask

  // Runs the FETCH cycle (MemRdy high) and the DECODE cycle, leaving the bench in the third cycle.
  task automatic fetchDecode(input logic [31:0] instr);
    setInstr(instr);
    MemRdy = 1'b1;
    settle();
    checkVal("fetch.state", State, 32'd0);
    checkVal("fetch.memreq", MemReq, 32'd1);
    checkVal("fetch.irwr", IRWr, 32'd1);
    checkVal("fetch.pcwr", PcWr, 32'd1);
    checkVal("fetch.srcb", AluSrcB, 32'd1);
    tick();
    settle();
    checkVal("decode.state", State, 32'd1);
    checkVal("decode.srcb", AluSrcB, 32'd3);
    checkVal("decode.ext", ExtOp, 32'd1);
    tick();
  endtask

  logic [5:0] rFn  [7] = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02};
  logic [4:0] rAlu [7] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6};
  logic [5:0] iOp  [6] = '{6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0F};
  logic [4:0] iAlu [6] = '{5'd0, 5'd0, 5'd4, 5'd2, 5'd3, 5'd7};
  logic [1:0] iExt [6] = '{2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd2};

  initial begin
    Reset = 1'b0; Zero = 1'b0; MemRdy = 1'b1; opc = 6'h00; fn = 6'h00;
    tick(); settle();
    checkVal("rst.state", State, 32'd0);
    checkVal("rst.memreq", MemReq, 32'd0);
    checkVal("rst.irwr", IRWr, 32'd0);
    checkVal("rst.srcb", AluSrcB, 32'd0);
    checkVal("rst.illegal", IllegalOp, 32'd0);
    checkVal("rst.buserr", BusErr, 32'd0);
    tick();
    Reset = 1'b1;

    // addu $3,$1,$2
    fetchDecode(32'h00221821);
    settle();
    checkVal("addu.exe.state", State, 32'd2);
    checkVal("addu.exe.srca", AluSrcA, 32'd1);
    checkVal("addu.exe.srcb", AluSrcB, 32'd0);
    checkVal("addu.exe.alu", Aluctrl, 32'd0);
    tick(); settle();
    checkVal("addu.wb.state", State, 32'd4);
    checkVal("addu.wb.regw", RegW, 32'd1);
    checkVal("addu.wb.regdst", RegDst, 32'd1);
    checkVal("addu.wb.mem2r", Mem2R, 32'd0);
    tick();

    for (int i = 0; i < 7; i++) begin
      fetchDecode({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, rFn[i]});
      settle();
      checkVal("rtype.exe.state", State, 32'd2);
      checkVal("rtype.exe.alu", Aluctrl, rAlu[i]);
      tick(); settle();
      checkVal("rtype.wb.state", State, 32'd4);
      tick();
    end

    for (int i = 0; i < 6; i++) begin
      fetchDecode({iOp[i], 5'd1, 5'd2, 16'h0010});
      settle();
      checkVal("itype.exe.state", State, 32'd3);
      checkVal("itype.exe.srca", AluSrcA, 32'd1);
      checkVal("itype.exe.srcb", AluSrcB, 32'd2);
      checkVal("itype.exe.alu", Aluctrl, iAlu[i]);
      checkVal("itype.exe.ext", ExtOp, iExt[i]);
      tick(); settle();
      checkVal("itype.wb.state", State, 32'd4);
      checkVal("itype.wb.regw", RegW, 32'd1);
      checkVal("itype.wb.regdst", RegDst, 32'd0);
      tick();
    end

    // lw $2,8($1) with three wait states: 8 cycles total
    fetchDecode(32'h8C220008);
    settle();
    checkVal("lw.addr.state", State, 32'd5);
    checkVal("lw.addr.srcb", AluSrcB, 32'd2);
    checkVal("lw.addr.ext", ExtOp, 32'd1);
    tick();
    MemRdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      checkVal("lw.wait.state", State, 32'd6);
      checkVal("lw.wait.memreq", MemReq, 32'd1);
      checkVal("lw.wait.iord", IorD, 32'd1);
      tick();
    end
    MemRdy = 1'b1;
    settle();
    checkVal("lw.rd.state", State, 32'd6);
    tick(); settle();
    checkVal("lw.wb.state", State, 32'd8);
    checkVal("lw.wb.regw", RegW, 32'd1);
    checkVal("lw.wb.mem2r", Mem2R, 32'd1);
    checkVal("lw.wb.regdst", RegDst, 32'd0);
    tick(); settle();
    checkVal("lw.done.state", State, 32'd0);

    // sw $2,8($1)
    fetchDecode(32'hAC220008);
    settle();
    checkVal("sw.addr.state", State, 32'd5);
    tick(); settle();
    checkVal("sw.wr.state", State, 32'd7);
    checkVal("sw.wr.memw", MemW, 32'd1);
    checkVal("sw.wr.iord", IorD, 32'd1);
    tick(); settle();
    checkVal("sw.done.state", State, 32'd0);

    // beq taken, bne not taken and taken
    Zero = 1'b1;
    fetchDecode(32'h10220004);
    settle();
    checkVal("beq.state", State, 32'd9);
    checkVal("beq.pcwr", PcWr, 32'd1);
    checkVal("beq.pcsrc", PcSrc, 32'd1);
    checkVal("beq.alu", Aluctrl, 32'd1);
    checkVal("beq.srca", AluSrcA, 32'd1);
    tick(); settle();
    checkVal("beq.done.state", State, 32'd0);
    fetchDecode(32'h14220004);
    settle();
    checkVal("bne.z1.state", State, 32'd9);
    checkVal("bne.z1.pcwr", PcWr, 32'd0);
    Zero = 1'b0;
    settle();
    checkVal("bne.z0.pcwr", PcWr, 32'd1);
    tick(); settle();
    checkVal("bne.done.state", State, 32'd0);

    fetchDecode(32'h08000010);
    settle();
    checkVal("j.state", State, 32'd10);
    checkVal("j.pcwr", PcWr, 32'd1);
    checkVal("j.pcsrc", PcSrc, 32'd2);
    tick();

    fetchDecode(32'h0C000040);
    settle();
    checkVal("jal.state", State, 32'd11);
    checkVal("jal.pcwr", PcWr, 32'd1);
    checkVal("jal.pcsrc", PcSrc, 32'd2);
    checkVal("jal.regw", RegW, 32'd1);
    checkVal("jal.regdst", RegDst, 32'd2);
    checkVal("jal.mem2r", Mem2R, 32'd2);
    tick();

    fetchDecode(32'h03E00008);
    settle();
    checkVal("jr.state", State, 32'd12);
    checkVal("jr.pcwr", PcWr, 32'd1);
    checkVal("jr.pcsrc", PcSrc, 32'd3);
    tick(); settle();
    checkVal("jr.done.state", State, 32'd0);

    checkVal("ill.before", IllegalOp, 32'd0);
    fetchDecode(32'hFC000000);
    settle();
    checkVal("ill.state", State, 32'd0);
    checkVal("ill.flag", IllegalOp, 32'd1);

    // MemRdy arrives exactly at the watchdog limit: normal fetch, no bus error
    setInstr(32'h00221821);
    MemRdy = 1'b0;
    for (int i = 0; i < 15; i++) begin
      settle();
      checkVal("rdywin.wait.state", State, 32'd0);
      checkVal("rdywin.wait.irwr", IRWr, 32'd0);
      tick();
    end
    MemRdy = 1'b1;
    settle();
    checkVal("rdywin.irwr", IRWr, 32'd1);
    tick(); settle();
    checkVal("rdywin.state", State, 32'd1);
    checkVal("rdywin.buserr", BusErr, 32'd0);
    tick(); tick(); tick();

    // MemRdy stuck low in FETCH: abort after 16 cycles
    MemRdy = 1'b0;
    for (int i = 0; i < 15; i++) begin
      settle();
      checkVal("wdog.wait.state", State, 32'd0);
      checkVal("wdog.wait.buserr", BusErr, 32'd0);
      tick();
    end
    settle();
    checkVal("wdog.last.irwr", IRWr, 32'd0);
    checkVal("wdog.last.pcwr", PcWr, 32'd0);
    tick(); settle();
    checkVal("wdog.buserr", BusErr, 32'd1);
    checkVal("wdog.state", State, 32'd0);
    checkVal("wdog.irwr", IRWr, 32'd0);

    // reset asserted while sw waits in MEM_WR
    fetchDecode(32'hAC220008);
    tick();
    MemRdy = 1'b0;
    settle();
    checkVal("rstmid.pre.state", State, 32'd7);
    Reset = 1'b0;
    settle();
    checkVal("rstmid.state", State, 32'd0);
    checkVal("rstmid.memreq", MemReq, 32'd0);
    checkVal("rstmid.memw", MemW, 32'd0);
    checkVal("rstmid.iord", IorD, 32'd0);
    checkVal("rstmid.illegal", IllegalOp, 32'd0);
    checkVal("rstmid.buserr", BusErr, 32'd0);
    tick();
    Reset = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
